secuenciador_programa: RTL and testbench

Fetch/decode/issue controller that sequences the 22-bit program memory. It holds the program counter and drives the memory address. It latches and classifies each instruction, issues ALU/load/store work to the execution datapath over a valid/done handshake, and resolves the BNEQ and B branches. It sits between the program memory and the register-file/ALU datapath.

---
 rtl/secuenciador_programa_if.sv | 23 ++
 rtl/secuenciador_programa.sv | 114 +++++++++++
 tb/tb_secuenciador_programa.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/secuenciador_programa_if.sv
// secuenciador_programa_if: program-memory and execution-datapath bus of the sequencer
interface secuenciador_programa_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 22
);
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               exec_valid;
  logic [4:0]         exec_op;
  logic [2:0]         exec_fa;
  logic [2:0]         exec_fb;
  logic [10:0]        exec_imm;
  logic               exec_done;
  logic               exec_neq;
  modport master (
    output mem_addr, exec_valid, exec_op, exec_fa, exec_fb, exec_imm,
    input  mem_data, exec_done, exec_neq
  );
  modport slave (
    input  mem_addr, exec_valid, exec_op, exec_fa, exec_fb, exec_imm,
    output mem_data, exec_done, exec_neq
  );
endinterface

// File: rtl/secuenciador_programa.sv
// secuenciador_programa: fetch/decode/issue controller; STEP_MODE_EN adds single-step (step/step_wait)
module secuenciador_programa #(
  parameter int ADDR_W     = 11,
  parameter int INSTR_W    = 22,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 2047
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef STEP_MODE_EN
  input  logic                  step,
  output logic                  step_wait,
`endif
  secuenciador_programa_if.master bus,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                err_q, err_d;
  logic                valid_q, busy_q, halted_q;
  logic                jump, inc, go, seq_end, tgt_bad;
  logic [4:0]          op;
  logic [10:0]         imm;
  assign op      = ir_q[21:17];
  assign imm     = ir_q[10:0];
  assign seq_end = pc_q == LAST;
  assign tgt_bad = int'(imm) > LAST_ADDR;
`ifdef STEP_MODE_EN
  logic step_wait_q;
  assign go        = step;
  assign step_wait = step_wait_q;
`else
  assign go = 1'b1;
`endif
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign err            = err_q;
  assign bus.mem_addr   = pc_q;
  assign bus.exec_valid = valid_q;
  assign bus.exec_op    = ir_q[21:17];
  assign bus.exec_fa    = ir_q[16:14];
  assign bus.exec_fb    = ir_q[13:11];
  assign bus.exec_imm   = ir_q[10:0];
  // next state: jump/inc select a branch or sequential PC update, which both halt at the boundary
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    jump    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE:   if (start) begin pc_d = START; state_d = FETCH; end
      FETCH:  if (go) begin ir_d = bus.mem_data; state_d = DECODE; end
      DECODE: begin
        jump    = op == 5'h12;
        inc     = op == 5'h1F;
        state_d = op <= 5'h11 ? EXEC : HALT;
        err_d   = err_q | (op > 5'h12 && op < 5'h1F);
      end
      EXEC: if (bus.exec_done) begin
        jump = op == 5'h11 && bus.exec_neq;
        inc  = !(op == 5'h11 && bus.exec_neq);
      end
      HALT:   if (start) begin err_d = 1'b0; pc_d = START; state_d = FETCH; end
      default: state_d = IDLE;
    endcase
    if (jump) begin
      state_d = tgt_bad ? HALT : FETCH;
      err_d   = err_q | tgt_bad;
      pc_d    = tgt_bad ? pc_q : ADDR_W'(imm);
    end
    if (inc) begin
      state_d = seq_end ? HALT : FETCH;
      pc_d    = seq_end ? pc_q : pc_q + 1'b1;
    end
  end
  // state and registered status outputs, decoded from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= START;
      ir_q     <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      valid_q  <= state_d == EXEC;
      busy_q   <= state_d inside {FETCH, DECODE, EXEC};
      halted_q <= state_d == HALT;
    end
  end
`ifdef STEP_MODE_EN
  // step_wait is high for every cycle spent in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_wait_q <= 1'b0;
    else     step_wait_q <= state_d == FETCH;
  end
`endif
endmodule

// File: tb/tb_secuenciador_programa.sv
// tb_secuenciador_programa: directed programs with a scoreboard of expected issues
module tb_secuenciador_programa;
  localparam int AW   = 11;
  localparam int LAST = 24;
  localparam logic [21:0] NOP = 22'h3FFFFF;
  typedef struct { int pc; logic [21:0] ins; int cyc; int next_pc; } exp_t;
  typedef struct { int lat; logic neq; } dp_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [AW-1:0] pc;
  logic busy, halted, err;
  logic [21:0] mem [0:2047];
  logic dp_done = 0;
  logic dp_neq = 0;
  logic man_done = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  dp_t  dp_q[$];
  secuenciador_programa_if #(.ADDR_W(AW), .INSTR_W(22)) bus ();
  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus.exec_done = dp_done | man_done;
  assign bus.exec_neq  = dp_neq;
`ifdef STEP_MODE_EN
  logic step_wait;
`endif
  secuenciador_programa #(.ADDR_W(AW), .INSTR_W(22), .START_ADDR(0), .LAST_ADDR(LAST)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef STEP_MODE_EN
    .step(1'b1),
    .step_wait(step_wait),
`endif
    .bus(bus),
    .pc(pc),
    .busy(busy),
    .halted(halted),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic issue(input int p, input logic [21:0] w, input int lat, input int cyc, input int nxt, input logic neq);
    exp_t e;
    dp_t d;
    mem[p] = w;
    e.pc = p; e.ins = w; e.cyc = cyc; e.next_pc = nxt;
    d.lat = lat; d.neq = neq;
    exp_q.push_back(e);
    dp_q.push_back(d);
  endtask
  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = NOP;
  endtask
  task automatic run(input string tag, input int exp_cyc);
    int cyc = 0;
    int t = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, "_start_pc"}, int'(pc), 0);
    chk({tag, "_start_err"}, int'(err), 0);
    chk({tag, "_start_busy"}, int'(busy), 1);
    chk({tag, "_start_halted"}, int'(halted), 0);
    while (!halted && t < 300) begin
      if (busy) cyc++;
      t++;
      @(negedge clk);
    end
    chk({tag, "_halted"}, int'(halted), 1);
    chk({tag, "_busy_cycles"}, cyc, exp_cyc);
  endtask
  // datapath model: acknowledges after the queued number of EXEC cycles (0 = never)
  int dcnt = 0;
  dp_t dcur;
  always @(negedge clk) begin
    if (bus.exec_valid) begin
      if (dcnt == 0) begin
        if (dp_q.size() != 0) dcur = dp_q.pop_front();
        else begin dcur.lat = 0; dcur.neq = 0; end
      end
      dcnt++;
      dp_done = dcur.lat != 0 && dcnt == dcur.lat;
      dp_neq  = dp_done & dcur.neq;
    end else begin
      dcnt = 0; dp_done = 0; dp_neq = 0;
    end
  end
  // monitor: checks each issued instruction and the PC once exec_valid falls
  logic prev_v = 0;
  bit have = 0;
  int vcnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (bus.exec_valid) begin
      if (!prev_v) begin
        have = exp_q.size() != 0;
        chk("issue_expected", int'(have), 1);
        if (have) begin
          cur = exp_q.pop_front();
          chk("issue_word", int'({bus.exec_op, bus.exec_fa, bus.exec_fb, bus.exec_imm}), int'(cur.ins));
          chk("issue_pc", int'(pc), cur.pc);
        end
        vcnt = 0;
      end
      vcnt++;
    end else if (prev_v && have) begin
      chk("exec_cycles", vcnt, cur.cyc);
      chk("pc_after_exec", int'(pc), cur.next_pc);
    end
    prev_v = bus.exec_valid;
  end
  initial begin
    int t;
    fill_nop();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(bus.exec_valid), 0);
    issue(0, 22'h000000, 2, 2, 1, 1'b0);
    mem[2] = {5'h12, 6'd0, 11'd8};
    issue(8,  {5'h11, 3'd1, 3'd2, 11'd12},  1, 1, 12, 1'b1);
    issue(12, {5'h05, 3'd3, 3'd4, 11'h2A5}, 3, 3, 13, 1'b0);
    issue(13, {5'h11, 3'd5, 3'd6, 11'd9},   1, 1, 14, 1'b0);
    issue(14, {5'h10, 3'd7, 3'd1, 11'h3FF}, 2, 2, 15, 1'b1);
    mem[15] = {5'h12, 6'd0, 11'd20};
    run("prog", 35);
    chk("prog_end_pc", int'(pc), LAST);
    chk("prog_end_err", int'(err), 0);
    chk("prog_queue_empty", exp_q.size(), 0);
    fill_nop();
    mem[3] = {5'h15, 17'd0};
    run("illegal", 8);
    chk("illegal_err", int'(err), 1);
    chk("illegal_pc", int'(pc), 3);
    fill_nop();
    mem[0] = {5'h12, 6'd0, 11'd25};
    run("bad_target", 2);
    chk("bad_target_err", int'(err), 1);
    chk("bad_target_pc", int'(pc), 0);
    fill_nop();
    issue(0, {5'h03, 3'd2, 3'd5, 11'h7FF}, 0, 5, 0, 1'b0);
    start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    while (!bus.exec_valid && t < 20) begin t++; @(negedge clk); end
    chk("abort_valid_seen", int'(bus.exec_valid), 1);
    repeat (4) @(negedge clk);
    #3 rst = 1;
    #1;
    chk("abort_valid", int'(bus.exec_valid), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_halted", int'(halted), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_op", int'(bus.exec_op), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      man_done = 1;
      @(negedge clk);
      chk("stray_done_valid", int'(bus.exec_valid), 0);
      chk("stray_done_busy", int'(busy), 0);
      chk("stray_done_pc", int'(pc), 0);
    end
    man_done = 0;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
